// File: rtl/fetch_stage_pkg.sv
// Shared definitions for the stack processor front end: opcodes the fetch
// stage cares about and the fetch control state encoding.
package definitions;

    localparam logic [8:0] HALT_OP = 9'h1FF;
    localparam logic [8:0] NOP_OP  = 9'h000;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } fetch_state_t;

endpackage

// File: rtl/fetch_stage_sat_counter.sv
// Saturating up-counter used for benchmark cycle and instruction counts.
// It sticks at all-ones instead of wrapping so long runs never report a
// deceptively small number.
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         en,
    output logic [W-1:0] count
);

    localparam logic [W-1:0] ONE = {{(W-1){1'b0}}, 1'b1};
    localparam logic [W-1:0] MAX = {W{1'b1}};

    // Count up when enabled, holding at the maximum once it is reached.
    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
        end else if (en && (count != MAX)) begin
            count <= count + ONE;
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// Instruction-register stage behind the program counter. Captures the ROM
// word at PC each cycle, tags it with its address and a valid bit, inserts
// bubbles on flush, holds on stall, and runs the IDLE/RUN/HALT control FSM
// together with saturating cycle and retired-instruction counters.
module fetch_stage
    import definitions::*;
#(
    parameter int IW = 9,
    parameter int AW = 9,
    parameter int CW = 16
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [AW-1:0] PC,
    input  logic [IW-1:0] instr_i,
    input  logic          start_i,
    input  logic          stall_i,
    input  logic          flush_i,
    output logic [IW-1:0] ir_o,
    output logic [AW-1:0] ir_pc_o,
    output logic          ir_valid_o,
    output logic          halted_o,
    output logic [CW-1:0] cycle_cnt_o,
    output logic [CW-1:0] instr_cnt_o
);

    localparam logic [IW-1:0] NOP_WORD  = IW'(NOP_OP);
    localparam logic [IW-1:0] HALT_WORD = IW'(HALT_OP);

    fetch_state_t  r_state;
    fetch_state_t  w_nextState;
    logic          w_captureEn;
    logic          w_runCycle;
    logic [IW-1:0] r_ir;
    logic [AW-1:0] r_irPc;
    logic          r_irValid;

    // Control state register; reset always returns the stage to IDLE.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Next state and capture decision: flush beats stall, and only a word
    // that is actually captured can halt the machine.
    always_comb begin
        w_nextState = r_state;
        w_captureEn = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (start_i) begin
                    w_nextState = RUN;
                end
            end
            RUN: begin
                if (!flush_i && !stall_i) begin
                    w_captureEn = 1'b1;
                    if (instr_i == HALT_WORD) begin
                        w_nextState = HALT;
                    end
                end
            end
            HALT: begin
                w_nextState = HALT;
            end
            default: begin
                w_nextState = IDLE;
            end
        endcase
    end

    assign w_runCycle = (r_state == RUN);

    // Instruction register: NOP while idle, bubble on flush, hold on stall,
    // and in HALT keep the halt word and its address but drop valid.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_ir      <= NOP_WORD;
            r_irPc    <= '0;
            r_irValid <= 1'b0;
        end else begin
            unique case (r_state)
                RUN: begin
                    if (flush_i) begin
                        r_ir      <= NOP_WORD;
                        r_irPc    <= PC;
                        r_irValid <= 1'b0;
                    end else if (w_captureEn) begin
                        r_ir      <= instr_i;
                        r_irPc    <= PC;
                        r_irValid <= 1'b1;
                    end
                end
                HALT: begin
                    r_irValid <= 1'b0;
                end
                default: begin
                    r_ir      <= NOP_WORD;
                    r_irValid <= 1'b0;
                end
            endcase
        end
    end

    sat_counter #(.W(CW)) u_cycleCounter (
        .clk   (clk),
        .reset (reset),
        .en    (w_runCycle),
        .count (cycle_cnt_o)
    );

    sat_counter #(.W(CW)) u_instrCounter (
        .clk   (clk),
        .reset (reset),
        .en    (w_captureEn),
        .count (instr_cnt_o)
    );

    assign ir_o       = r_ir;
    assign ir_pc_o    = r_irPc;
    assign ir_valid_o = r_irValid;
    assign halted_o   = (r_state == HALT);

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage. Each step drives the inputs, advances a
// behavioural model of the stage, queues the expected outputs and checks
// them against the DUT one edge later. A second instance with 4-bit counters
// runs the same stimulus so counter saturation is reached in a short run.
module tb_fetch_stage;
    import definitions::*;

    logic       clk = 1'b0;
    logic       reset;
    logic       start_i;
    logic       stall_i;
    logic       flush_i;
    logic [8:0] pcIn;
    logic [8:0] instrIn;

    logic [8:0]  irOut;
    logic [8:0]  irPcOut;
    logic        irValidOut;
    logic        haltedOut;
    logic [15:0] cycleCntOut;
    logic [15:0] instrCntOut;

    logic [8:0]  irSmall;
    logic [8:0]  irPcSmall;
    logic        irValidSmall;
    logic        haltedSmall;
    logic [3:0]  cycleCntSmall;
    logic [3:0]  instrCntSmall;

    typedef struct {
        logic [8:0]  ir;
        logic [8:0]  pc;
        logic        valid;
        logic        halted;
        logic [15:0] cyc;
        logic [15:0] ins;
        logic [3:0]  cycSmall;
        logic [3:0]  insSmall;
    } expect_t;

    expect_t sbQueue[$];

    int vectors    = 0;
    int miscompares = 0;

    // Behavioural model state: 0 idle, 1 run, 2 halt.
    int         mState = 0;
    logic [8:0] mIr    = 9'h000;
    logic [8:0] mPc    = 9'h000;
    logic       mValid = 1'b0;
    int         mCyc   = 0;
    int         mIns   = 0;

    always #5 clk = ~clk;

    fetch_stage dut (
        .clk         (clk),
        .reset       (reset),
        .PC          (pcIn),
        .instr_i     (instrIn),
        .start_i     (start_i),
        .stall_i     (stall_i),
        .flush_i     (flush_i),
        .ir_o        (irOut),
        .ir_pc_o     (irPcOut),
        .ir_valid_o  (irValidOut),
        .halted_o    (haltedOut),
        .cycle_cnt_o (cycleCntOut),
        .instr_cnt_o (instrCntOut)
    );

    fetch_stage #(.CW(4)) dutSmall (
        .clk         (clk),
        .reset       (reset),
        .PC          (pcIn),
        .instr_i     (instrIn),
        .start_i     (start_i),
        .stall_i     (stall_i),
        .flush_i     (flush_i),
        .ir_o        (irSmall),
        .ir_pc_o     (irPcSmall),
        .ir_valid_o  (irValidSmall),
        .halted_o    (haltedSmall),
        .cycle_cnt_o (cycleCntSmall),
        .instr_cnt_o (instrCntSmall)
    );

    function automatic logic [15:0] sat16(input int v);
        return (v > 65535) ? 16'hFFFF : 16'(v);
    endfunction

    function automatic logic [3:0] sat4(input int v);
        return (v > 15) ? 4'hF : 4'(v);
    endfunction

    task automatic compareVal(input string tag, input logic [15:0] observed,
                              input logic [15:0] expected);
        vectors++;
        assert (observed === expected) else begin
            miscompares++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    task automatic checkOutput();
        expect_t e;
        if (sbQueue.size() == 0) begin
            vectors++;
            miscompares++;
            $error("[TB] FAIL scoreboard_empty observed=0 expected=1");
        end else begin
            e = sbQueue.pop_front();
            compareVal("ir_o",          {7'd0, irOut},        {7'd0, e.ir});
            compareVal("ir_pc_o",       {7'd0, irPcOut},      {7'd0, e.pc});
            compareVal("ir_valid_o",    {15'd0, irValidOut},  {15'd0, e.valid});
            compareVal("halted_o",      {15'd0, haltedOut},   {15'd0, e.halted});
            compareVal("cycle_cnt_o",   cycleCntOut,          e.cyc);
            compareVal("instr_cnt_o",   instrCntOut,          e.ins);
            compareVal("cycle_cnt_sat", {12'd0, cycleCntSmall}, {12'd0, e.cycSmall});
            compareVal("instr_cnt_sat", {12'd0, instrCntSmall}, {12'd0, e.insSmall});
        end
    endtask

    // Drive one cycle of inputs, predict the post-edge outputs, then check.
    task automatic applyStimulus(input logic rst, input logic st, input logic stl,
                                 input logic fl, input logic [8:0] p,
                                 input logic [8:0] ins);
        expect_t e;
        reset   = rst;
        start_i = st;
        stall_i = stl;
        flush_i = fl;
        pcIn    = p;
        instrIn = ins;

        if (rst) begin
            mState = 0;
            mIr    = 9'h000;
            mPc    = 9'h000;
            mValid = 1'b0;
            mCyc   = 0;
            mIns   = 0;
        end else if (mState == 0) begin
            mIr    = 9'h000;
            mValid = 1'b0;
            if (st) mState = 1;
        end else if (mState == 1) begin
            mCyc++;
            if (fl) begin
                mIr    = 9'h000;
                mPc    = p;
                mValid = 1'b0;
            end else if (!stl) begin
                mIr    = ins;
                mPc    = p;
                mValid = 1'b1;
                mIns++;
                if (ins == 9'h1FF) mState = 2;
            end
        end else begin
            mValid = 1'b0;
        end

        e.ir       = mIr;
        e.pc       = mPc;
        e.valid    = mValid;
        e.halted   = (mState == 2);
        e.cyc      = sat16(mCyc);
        e.ins      = sat16(mIns);
        e.cycSmall = sat4(mCyc);
        e.insSmall = sat4(mIns);
        sbQueue.push_back(e);

        @(posedge clk);
        #1;
        checkOutput();
    endtask

    initial begin
        reset   = 1'b1;
        start_i = 1'b0;
        stall_i = 1'b0;
        flush_i = 1'b0;
        pcIn    = 9'h000;
        instrIn = 9'h000;

        $display("[TB] reset then idle");
        applyStimulus(1, 0, 0, 0, 9'd0, 9'h000);
        applyStimulus(1, 0, 0, 0, 9'd0, 9'h000);
        for (int i = 0; i < 5; i++)
            applyStimulus(0, 0, 0, 0, 9'(i), 9'h0AB);

        $display("[TB] straight-line run with stall");
        applyStimulus(0, 1, 0, 0, 9'd0, 9'h011);
        applyStimulus(0, 0, 0, 0, 9'd0, 9'h011);
        applyStimulus(0, 0, 0, 0, 9'd1, 9'h022);
        applyStimulus(0, 0, 1, 0, 9'd2, 9'h033);
        applyStimulus(0, 0, 1, 0, 9'd2, 9'h033);
        applyStimulus(0, 0, 1, 0, 9'd2, 9'h033);
        applyStimulus(0, 0, 0, 0, 9'd2, 9'h033);
        applyStimulus(0, 0, 0, 0, 9'd3, 9'h044);

        $display("[TB] flush versus stall");
        applyStimulus(0, 0, 1, 1, 9'd4, 9'h055);
        applyStimulus(0, 0, 0, 0, 9'd5, 9'h066);
        applyStimulus(0, 0, 0, 1, 9'd6, 9'h077);

        $display("[TB] long run past small-counter saturation");
        for (int i = 0; i < 20; i++)
            applyStimulus(0, 0, ($urandom_range(0, 3) == 0), 0, 9'(500 + i),
                          9'($urandom_range(0, 9'h1FE)));

        $display("[TB] halt under flush, halt under stall, then halt");
        applyStimulus(0, 0, 0, 1, 9'd6, 9'h1FF);
        applyStimulus(0, 0, 1, 0, 9'd7, 9'h1FF);
        applyStimulus(0, 0, 0, 0, 9'd7, 9'h1FF);
        for (int i = 0; i < 10; i++)
            applyStimulus(0, 1, 0, 0, 9'(8 + i), 9'h012);

        $display("[TB] restart then reset during run");
        applyStimulus(1, 0, 0, 0, 9'd0, 9'h000);
        applyStimulus(0, 1, 0, 0, 9'd0, 9'h000);
        applyStimulus(0, 0, 0, 0, 9'd40, 9'h0C3);
        applyStimulus(0, 0, 0, 0, 9'd41, 9'h0C4);
        applyStimulus(1, 0, 0, 0, 9'd42, 9'h0C5);
        applyStimulus(0, 0, 0, 0, 9'd43, 9'h0C6);
        applyStimulus(0, 0, 0, 0, 9'd44, 9'h0C7);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
